// File: rtl/rv_regfile_wb_if.sv
// Bundle of the register-file ports seen by decode/execute and the data-memory side.
// master = pipeline driving requests; slave = the register file.
interface rv_regfile_wb_if #(
   parameter int XLEN = 32,
   parameter int NREG = 32
);
   localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;

   logic [AW-1:0]   rs1_addr;
   logic [AW-1:0]   rs2_addr;
   logic            rs1_used;
   logic            rs2_used;
   logic [XLEN-1:0] rs1_data;
   logic [XLEN-1:0] rs2_data;
   logic            stall;

   logic            wb_en;
   logic [1:0]      wb_sel;
   logic [AW-1:0]   wb_addr;
   logic [XLEN-1:0] alu_res;
   logic [XLEN-1:0] lui_imm;
   logic [XLEN-1:0] ret_addr;

   logic            ld_issue;
   logic [AW-1:0]   ld_dest;
   logic            ld_rsp_valid;
   logic            ld_rsp_ready;
   logic [AW-1:0]   ld_rsp_addr;
   logic [XLEN-1:0] ld_rsp_data;

   logic            st_req;
   logic [AW-1:0]   st_src;
   logic            st_valid;
   logic            st_ready;
   logic [XLEN-1:0] st_data;

   logic            pend_any;

   modport master (
      output rs1_addr, rs2_addr, rs1_used, rs2_used,
      input  rs1_data, rs2_data, stall,
      output wb_en, wb_sel, wb_addr, alu_res, lui_imm, ret_addr,
      output ld_issue, ld_dest, ld_rsp_valid, ld_rsp_addr, ld_rsp_data,
      input  ld_rsp_ready,
      output st_req, st_src, st_ready,
      input  st_valid, st_data,
      input  pend_any
   );

   modport slave (
      input  rs1_addr, rs2_addr, rs1_used, rs2_used,
      output rs1_data, rs2_data, stall,
      input  wb_en, wb_sel, wb_addr, alu_res, lui_imm, ret_addr,
      input  ld_issue, ld_dest, ld_rsp_valid, ld_rsp_addr, ld_rsp_data,
      output ld_rsp_ready,
      input  st_req, st_src, st_ready,
      output st_valid, st_data,
      output pend_any
   );
endinterface

// File: rtl/rv_regfile_wb.sv
// RV32I integer register file: prioritised write-back, write-through bypass,
// pending-load scoreboard with hazard stall, and a registered store-data channel.
module rv_regfile_wb #(
   parameter int XLEN       = 32,
   parameter int NREG       = 32,
   parameter int RESET_INIT = 0
) (
   input  logic             clk,
   input  logic             rst,
   rv_regfile_wb_if.slave   bus
);
   localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;

   logic [XLEN-1:0] regs [NREG];
   logic [NREG-1:0] pend;
   logic [NREG-1:0] pend_next;

   logic            wb_write;
   logic            ld_accept;
   logic            wr_en;
   logic [AW-1:0]   wr_addr;
   logic [XLEN-1:0] wr_data;
   logic [XLEN-1:0] wb_value;

   logic            st_valid_q;
   logic [XLEN-1:0] st_data_q;
   logic            st_fire;
   logic [XLEN-1:0] st_operand;

   // Architectural write-back always wins the single write port; loads wait.
   assign wb_write          = bus.wb_en && (bus.wb_sel != 2'd3);
   assign bus.ld_rsp_ready  = !wb_write;
   assign ld_accept         = bus.ld_rsp_valid && !wb_write;

   always_comb begin
      wb_value = bus.alu_res;
      case (bus.wb_sel)
         2'd0:    wb_value = bus.alu_res;
         2'd1:    wb_value = bus.lui_imm;
         2'd2:    wb_value = bus.ret_addr;
         default: wb_value = bus.alu_res;
      endcase
   end

   always_comb begin
      wr_addr = '0;
      wr_data = '0;
      if (wb_write) begin
         wr_addr = bus.wb_addr;
         wr_data = wb_value;
      end else if (ld_accept) begin
         wr_addr = bus.ld_rsp_addr;
         wr_data = bus.ld_rsp_data;
      end
   end

   assign wr_en = (wb_write || ld_accept) && (wr_addr != '0);

   function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] addr);
      if (addr == '0)
         return '0;
      else if (wr_en && (wr_addr == addr))
         return wr_data;
      else
         return regs[addr];
   endfunction

   assign bus.rs1_data = read_port(bus.rs1_addr);
   assign bus.rs2_data = read_port(bus.rs2_addr);
   assign st_operand   = read_port(bus.st_src);

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < NREG; i++)
            regs[i] <= (RESET_INIT != 0) ? XLEN'(i) : '0;
      end else if (wr_en) begin
         regs[wr_addr] <= wr_data;
      end
   end

   // Clear before set so an issue and a response to the same register leave it pending.
   always_comb begin
      pend_next = pend;
      if (ld_accept)
         pend_next[bus.ld_rsp_addr] = 1'b0;
      if (bus.ld_issue && (bus.ld_dest != '0))
         pend_next[bus.ld_dest] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst)
         pend <= '0;
      else
         pend <= pend_next;
   end

   assign bus.stall = (bus.rs1_used && pend[bus.rs1_addr] && (bus.rs1_addr != '0)) ||
                      (bus.rs2_used && pend[bus.rs2_addr] && (bus.rs2_addr != '0));
   assign bus.pend_any = |pend;

   assign st_fire = bus.st_req && (!st_valid_q || bus.st_ready);

   always_ff @(posedge clk) begin
      if (!rst) begin
         st_valid_q <= 1'b0;
         st_data_q  <= '0;
      end else if (st_fire) begin
         st_valid_q <= 1'b1;
         st_data_q  <= st_operand;
      end else if (bus.st_ready) begin
         st_valid_q <= 1'b0;
      end
   end

   assign bus.st_valid = st_valid_q;
   assign bus.st_data  = st_data_q;
endmodule

// File: tb/tb_rv_regfile_wb.sv
// Self-checking bench for rv_regfile_wb: directed scenarios followed by random
// traffic, all compared against an array/bit-vector reference model.
module tb_rv_regfile_wb;
   localparam int XLEN = 32;
   localparam int NREG = 32;
   localparam int AW   = 5;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   rv_regfile_wb_if #(.XLEN(XLEN), .NREG(NREG)) bus ();

   rv_regfile_wb #(.XLEN(XLEN), .NREG(NREG), .RESET_INIT(1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int tests = 0;
   int fails = 0;

   logic [XLEN-1:0] mregs [NREG];
   logic [NREG-1:0] mpend;
   logic            mst_valid;
   logic [XLEN-1:0] mst_data;
   logic            mw_en;
   logic [AW-1:0]   mw_addr;
   logic [XLEN-1:0] mw_data;
   logic            m_ready;

   task automatic check_output(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Decide which write, if any, takes the port this cycle.
   task automatic model_write_info();
      logic wb_write;
      wb_write = bus.wb_en && (bus.wb_sel != 2'd3);
      m_ready  = !wb_write;
      mw_addr  = '0;
      mw_data  = '0;
      if (wb_write) begin
         mw_addr = bus.wb_addr;
         mw_data = (bus.wb_sel == 2'd0) ? bus.alu_res :
                   (bus.wb_sel == 2'd1) ? bus.lui_imm : bus.ret_addr;
      end else if (bus.ld_rsp_valid) begin
         mw_addr = bus.ld_rsp_addr;
         mw_data = bus.ld_rsp_data;
      end
      mw_en = (wb_write || (bus.ld_rsp_valid && m_ready)) && (mw_addr != 0);
   endtask

   function automatic logic [XLEN-1:0] model_read(input logic [AW-1:0] a);
      if (a == 0) return '0;
      if (mw_en && (mw_addr == a)) return mw_data;
      return mregs[a];
   endfunction

   task automatic step();
      logic exp_stall;
      #1;
      model_write_info();
      if (rst) begin
         exp_stall = (bus.rs1_used && mpend[bus.rs1_addr] && (bus.rs1_addr != 0)) ||
                     (bus.rs2_used && mpend[bus.rs2_addr] && (bus.rs2_addr != 0));
         check_output("rs1_data", bus.rs1_data, model_read(bus.rs1_addr));
         check_output("rs2_data", bus.rs2_data, model_read(bus.rs2_addr));
         check_output("stall", 32'(bus.stall), 32'(exp_stall));
         check_output("ld_rsp_ready", 32'(bus.ld_rsp_ready), 32'(m_ready));
         check_output("pend_any", 32'(bus.pend_any), 32'(mpend != '0));
         check_output("st_valid", 32'(bus.st_valid), 32'(mst_valid));
         check_output("st_data", bus.st_data, mst_data);
      end
   endtask

   task automatic tick();
      model_write_info();
      if (!rst) begin
         for (int i = 0; i < NREG; i++) mregs[i] = XLEN'(i);
         mpend     = '0;
         mst_valid = 1'b0;
         mst_data  = '0;
      end else begin
         if (bus.st_req && (!mst_valid || bus.st_ready)) begin
            mst_data  = model_read(bus.st_src);
            mst_valid = 1'b1;
         end else if (bus.st_ready) begin
            mst_valid = 1'b0;
         end
         if (bus.ld_rsp_valid && m_ready) mpend[bus.ld_rsp_addr] = 1'b0;
         if (bus.ld_issue && (bus.ld_dest != 0)) mpend[bus.ld_dest] = 1'b1;
         if (mw_en) mregs[mw_addr] = mw_data;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic clear_inputs();
      bus.rs1_addr = '0;  bus.rs2_addr = '0;  bus.rs1_used = 0;  bus.rs2_used = 0;
      bus.wb_en = 0;      bus.wb_sel = '0;    bus.wb_addr = '0;
      bus.alu_res = '0;   bus.lui_imm = '0;   bus.ret_addr = '0;
      bus.ld_issue = 0;   bus.ld_dest = '0;   bus.ld_rsp_valid = 0;
      bus.ld_rsp_addr = '0; bus.ld_rsp_data = '0;
      bus.st_req = 0;     bus.st_src = '0;    bus.st_ready = 0;
   endtask

   task automatic apply_stimulus();
      rst              = ($urandom_range(0, 63) != 0);
      bus.rs1_addr     = AW'($urandom_range(0, 7));
      bus.rs2_addr     = AW'($urandom_range(0, 7));
      bus.rs1_used     = 1'($urandom_range(0, 1));
      bus.rs2_used     = 1'($urandom_range(0, 1));
      bus.wb_en        = ($urandom_range(0, 2) == 0);
      bus.wb_sel       = 2'($urandom_range(0, 3));
      bus.wb_addr      = AW'($urandom_range(0, 7));
      bus.alu_res      = $urandom;
      bus.lui_imm      = $urandom;
      bus.ret_addr     = $urandom;
      bus.ld_issue     = ($urandom_range(0, 3) == 0);
      bus.ld_dest      = AW'($urandom_range(0, 7));
      bus.ld_rsp_valid = 1'($urandom_range(0, 1));
      bus.ld_rsp_addr  = AW'($urandom_range(0, 7));
      bus.ld_rsp_data  = $urandom;
      bus.st_req       = 1'($urandom_range(0, 1));
      bus.st_src       = AW'($urandom_range(0, 31));
      bus.st_ready     = 1'($urandom_range(0, 1));
   endtask

   initial begin
      clear_inputs();
      rst = 1'b0;
      @(negedge clk);
      tick();
      tick();
      rst = 1'b1;

      // Debug reset pattern and x0 immutability.
      bus.rs1_addr = 5'd5;
      step();
      check_output("x5_init", bus.rs1_data, 32'd5);
      check_output("x0_init", bus.rs2_data, 32'd0);
      check_output("st_data_rst", bus.st_data, 32'd0);
      tick();
      bus.wb_en = 1; bus.wb_sel = 2'd0; bus.wb_addr = 5'd0; bus.alu_res = 32'hDEADBEEF;
      bus.rs1_addr = 5'd0;
      step();
      tick();
      bus.wb_en = 0;
      step();
      check_output("x0_after_write", bus.rs1_data, 32'd0);
      tick();

      // Same-cycle bypass of a LUI write-back.
      bus.wb_en = 1; bus.wb_sel = 2'd1; bus.wb_addr = 5'd3; bus.lui_imm = 32'h12345000;
      bus.rs1_addr = 5'd3;
      step();
      check_output("lui_bypass", bus.rs1_data, 32'h12345000);
      tick();
      bus.wb_en = 0;
      step();
      check_output("lui_stored", bus.rs1_data, 32'h12345000);
      tick();

      // Read-after-load hazard on x7.
      bus.ld_issue = 1; bus.ld_dest = 5'd7;
      step();
      tick();
      bus.ld_issue = 0; bus.rs2_used = 1; bus.rs2_addr = 5'd7;
      step();
      check_output("stall_x7", 32'(bus.stall), 32'd1);
      tick();
      bus.ld_rsp_valid = 1; bus.ld_rsp_addr = 5'd7; bus.ld_rsp_data = 32'hA5;
      bus.ld_issue = 1; bus.ld_dest = 5'd8;
      step();
      tick();
      bus.ld_rsp_valid = 0; bus.ld_issue = 0;
      step();
      check_output("stall_cleared", 32'(bus.stall), 32'd0);
      check_output("x7_loaded", bus.rs2_data, 32'hA5);
      tick();
      bus.rs2_used = 0;

      // Write-back blocks a load response for one cycle.
      bus.wb_en = 1; bus.wb_sel = 2'd2; bus.wb_addr = 5'd1; bus.ret_addr = 32'h104;
      bus.ld_rsp_valid = 1; bus.ld_rsp_addr = 5'd8; bus.ld_rsp_data = 32'h77;
      step();
      check_output("ready_blocked", 32'(bus.ld_rsp_ready), 32'd0);
      tick();
      bus.wb_en = 0; bus.rs1_addr = 5'd1; bus.rs2_addr = 5'd8;
      step();
      check_output("ready_open", 32'(bus.ld_rsp_ready), 32'd1);
      check_output("x1_ret", bus.rs1_data, 32'h104);
      check_output("x8_bypass", bus.rs2_data, 32'h77);
      tick();
      bus.ld_rsp_valid = 0;
      step();
      check_output("pend_any_idle", 32'(bus.pend_any), 32'd0);
      tick();

      // Store operand held under back-pressure; a second request is ignored.
      bus.wb_en = 1; bus.wb_sel = 2'd0; bus.wb_addr = 5'd4; bus.alu_res = 32'h55;
      step();
      tick();
      bus.wb_en = 0; bus.st_req = 1; bus.st_src = 5'd4; bus.st_ready = 0;
      step();
      tick();
      bus.st_req = 0;
      for (int i = 0; i < 3; i++) begin
         if (i == 1) begin bus.st_req = 1; bus.st_src = 5'd5; end
         else bus.st_req = 0;
         step();
         check_output("st_hold_valid", 32'(bus.st_valid), 32'd1);
         check_output("st_hold_data", bus.st_data, 32'h55);
         tick();
      end
      bus.st_req = 0; bus.st_ready = 1;
      step();
      tick();
      step();
      check_output("st_drained", 32'(bus.st_valid), 32'd0);
      tick();
      bus.st_ready = 0;

      // Issue and response to x9 in the same cycle: set wins.
      bus.ld_issue = 1; bus.ld_dest = 5'd9;
      bus.ld_rsp_valid = 1; bus.ld_rsp_addr = 5'd9; bus.ld_rsp_data = 32'h99;
      step();
      tick();
      bus.ld_issue = 0; bus.ld_rsp_valid = 0; bus.rs1_used = 1; bus.rs1_addr = 5'd9;
      step();
      check_output("x9_still_pending", 32'(bus.stall), 32'd1);
      check_output("x9_pend_any", 32'(bus.pend_any), 32'd1);
      check_output("x9_data", bus.rs1_data, 32'h99);
      tick();

      // Random traffic, including occasional mid-run resets.
      for (int n = 0; n < 400; n++) begin
         apply_stimulus();
         step();
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/rv_regfile_wb.md
# rv_regfile_wb

Parametrised integer register file for the RV32I core. It replaces the single-source write path with a prioritised write-back mux and hardwires x0 to zero. It adds a write-through bypass, a pending-load scoreboard with a valid/ready load-response port and hazard stall, and a registered store-data channel with a valid/ready handshake. It sits between decode/execute and the data-memory interface.

## Interface
Parameters:
- XLEN, 32, data width of every register.
- NREG, 32, number of registers; power of two, minimum 2. AW = log2(NREG) is derived internally.
- RESET_INIT, 0, reset pattern: 0 = all registers zero; 1 = register i holds value i (debug pattern; x0 still reads 0).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-low.
- rs1_addr, rs2_addr  in  AW  read addresses.
- rs1_used, rs2_used  in  1  current instruction consumes rs1 / rs2.
- rs1_data, rs2_data  out  XLEN  read data, combinational.
- stall  out  1  read-after-load hazard.
- wb_en  in  1  architectural write-back request.
- wb_sel  in  2  write-back source: 0 = alu_res, 1 = lui_imm, 2 = ret_addr, 3 = reserved (no write).
- wb_addr  in  AW  write-back destination.
- alu_res, lui_imm, ret_addr  in  XLEN  write-back sources.
- ld_issue  in  1  a load to ld_dest is issued.
- ld_dest  in  AW  destination of the issued load.
- ld_rsp_valid  in  1  load data is available.
- ld_rsp_ready  out  1  the block accepts load data this cycle.
- ld_rsp_addr  in  AW  destination of the returned load.
- ld_rsp_data  in  XLEN  returned load data.
- st_req  in  1  capture a store operand.
- st_src  in  AW  register to capture.
- st_valid  out  1  st_data holds an unaccepted operand.
- st_ready  in  1  memory accepts st_data.
- st_data  out  XLEN  registered store operand.
- pend_any  out  1  at least one scoreboard bit is set.

## Operation
- Write port: one write per cycle. Priority: wb_en with wb_sel 0–2 first, then an accepted load response.
- ld_rsp_ready = !(wb_en && wb_sel != 3). A load response writes when ld_rsp_valid && ld_rsp_ready.
- x0: reads return 0. Writes to x0 are dropped. ld_issue to x0 sets no pending bit.
- Bypass: a read of the address being written this cycle (by wb or by an accepted load) returns the new data, not the stored value.
- Scoreboard, one bit per register:
  - ld_issue sets pend[ld_dest].
  - An accepted response clears pend[ld_rsp_addr].
  - If ld_issue and an accepted response target the same address in the same cycle, the data is written and the bit stays set (set wins).
  - A wb_en write to a pending register performs the write and leaves the bit unchanged.
- stall = (rs1_used && pend[rs1_addr] && rs1_addr != 0) || (the same term for rs2). stall does not account for a response accepted in the same cycle.
- Store channel:
  - If st_req && (!st_valid || st_ready), st_data <= bypassed value of st_src and st_valid <= 1.
  - Otherwise, if st_ready, st_valid <= 0.
  - A st_req while st_valid && !st_ready is ignored; the upstream stage must hold it.
- pend_any = OR of all scoreboard bits.

## Timing
- Reset (rst = 0 at clk edge):
  - Registers take the RESET_INIT pattern.
  - All scoreboard bits clear; stall = 0 when no register is pending.
  - st_valid = 0, st_data = 0, pend_any = 0.
  - All requests in the reset cycle are ignored, including a reset that lands mid-transfer. An in-flight load response after reset is discarded only if ld_rsp_valid is also dropped upstream; the block itself accepts it normally.
- Read latency: 0 cycles (combinational).
- Write latency: data is visible through the bypass in the same cycle and from storage in the next cycle.
- Scoreboard: a bit set at edge N gives stall in cycle N+1. A bit cleared at edge N removes stall in cycle N+1.
- Store channel: st_data is valid 1 cycle after an accepted st_req. Back-to-back transfers run at 1 per cycle while st_ready = 1.
- ld_rsp_ready is combinational from wb_en and wb_sel; there is no combinational path from ld_rsp_valid.

## Test plan
- Reset with RESET_INIT = 1, then read x5 and x0 -> 5 and 0. Write 0xDEADBEEF to x0 via wb_sel 0 -> x0 still reads 0.
- Same cycle: wb_en, wb_sel 1, wb_addr 3, lui_imm 0x12345000, rs1_addr 3 -> rs1_data = 0x12345000 in that cycle; x3 holds it afterwards.
- ld_issue x7, next cycle rs2_used with rs2_addr 7 -> stall = 1. Response ld_rsp_addr 7, data 0xA5 -> stall = 0 on the next cycle; x7 = 0xA5.
- ld_rsp_valid while wb_en with wb_sel 2, ret_addr 0x104 to x1 -> ld_rsp_ready = 0; x1 = 0x104. Load accepted the following cycle.
- st_req x4 (= 0x55) with st_ready = 0 for 3 cycles -> st_valid held and st_data = 0x55 stable. A second st_req during the hold is ignored.
- ld_issue and ld_rsp to x9 in the same cycle -> data written, pend[9] remains 1, pend_any = 1.
